// File: rtl/core_types_pkg.sv
// Shared types for the multi-lane rename map table.
// Holds the tag widths, lane count and the checkpoint column layout.
package core_types_pkg;
  localparam int NUM_ARCH_REGS      = 32;
  localparam int NUM_PHYS_REGS      = 64;
  localparam int RENAME_WIDTH       = 2;
  localparam int CHECKPOINT_COLUMNS = 4;
  localparam int ROB_DEPTH          = 64;

  localparam int AW     = $clog2(NUM_ARCH_REGS);
  localparam int PW     = $clog2(NUM_PHYS_REGS);
  localparam int CW     = $clog2(CHECKPOINT_COLUMNS);
  localparam int RW_IDX = $clog2(ROB_DEPTH);

  typedef logic [AW-1:0]     arch_reg_tag_t;
  typedef logic [PW-1:0]     phys_reg_tag_t;
  typedef logic [RW_IDX-1:0] ROB_index_t;
  typedef logic [CW-1:0]     checkpoint_column_t;

  typedef struct packed {
    logic                                valid;
    ROB_index_t                          rob_index;
    phys_reg_tag_t [NUM_ARCH_REGS-1:0]   map;
  } map_column_t;

  function automatic map_column_t identity_column();
    map_column_t col;
    col       = '0;
    col.valid = 1'b1;
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      col.map[r] = phys_reg_tag_t'(r);
    end
    return col;
  endfunction
endpackage

// File: rtl/rename_bypass_network.sv
// Per-lane priority match: a lane sees the newest older-lane rename of the
// same architectural register in place of the table value.
module rename_bypass_network
  import core_types_pkg::*;
(
  input  arch_reg_tag_t [RENAME_WIDTH-1:0] src0_arch_i,
  input  arch_reg_tag_t [RENAME_WIDTH-1:0] src1_arch_i,
  input  arch_reg_tag_t [RENAME_WIDTH-1:0] dest_arch_i,
  input  logic          [RENAME_WIDTH-1:0] rename_valid_i,
  input  phys_reg_tag_t [RENAME_WIDTH-1:0] dest_phys_i,
  input  phys_reg_tag_t [RENAME_WIDTH-1:0] src0_table_i,
  input  phys_reg_tag_t [RENAME_WIDTH-1:0] src1_table_i,
  input  phys_reg_tag_t [RENAME_WIDTH-1:0] old_table_i,
  output phys_reg_tag_t [RENAME_WIDTH-1:0] src0_phys_o,
  output phys_reg_tag_t [RENAME_WIDTH-1:0] src1_phys_o,
  output phys_reg_tag_t [RENAME_WIDTH-1:0] old_phys_o
);

  // Ascending scan so the highest matching older lane overrides lower ones.
  always_comb begin
    src0_phys_o = src0_table_i;
    src1_phys_o = src1_table_i;
    old_phys_o  = old_table_i;
    for (int k = 1; k < RENAME_WIDTH; k++) begin
      for (int j = 0; j < k; j++) begin
        src0_phys_o[k] = (rename_valid_i[j] && dest_arch_i[j] == src0_arch_i[k]) ? dest_phys_i[j] : src0_phys_o[k];
        src1_phys_o[k] = (rename_valid_i[j] && dest_arch_i[j] == src1_arch_i[k]) ? dest_phys_i[j] : src1_phys_o[k];
        old_phys_o[k]  = (rename_valid_i[j] && dest_arch_i[j] == dest_arch_i[k]) ? dest_phys_i[j] : old_phys_o[k];
      end
    end
  end

endmodule

// File: rtl/multi_lane_rename_map_table.sv
// Multi-lane register map table with a circular buffer of checkpoint columns.
// Handles rename, save, revert, tagged restore and out-of-order release.
module multi_lane_rename_map_table
  import core_types_pkg::*;
(
  input  logic                             CLK,
  input  logic                             RST,
  input  arch_reg_tag_t [RENAME_WIDTH-1:0] src_arch_tag_0,
  output phys_reg_tag_t [RENAME_WIDTH-1:0] src_phys_tag_0,
  input  arch_reg_tag_t [RENAME_WIDTH-1:0] src_arch_tag_1,
  output phys_reg_tag_t [RENAME_WIDTH-1:0] src_phys_tag_1,
  input  logic          [RENAME_WIDTH-1:0] rename_valid,
  input  arch_reg_tag_t [RENAME_WIDTH-1:0] rename_dest_arch_tag,
  input  phys_reg_tag_t [RENAME_WIDTH-1:0] rename_dest_phys_tag,
  output phys_reg_tag_t [RENAME_WIDTH-1:0] old_dest_phys_tag,
  input  logic          [RENAME_WIDTH-1:0] revert_valid,
  input  arch_reg_tag_t [RENAME_WIDTH-1:0] revert_dest_arch_tag,
  input  phys_reg_tag_t [RENAME_WIDTH-1:0] revert_safe_phys_tag,
  input  logic                             save_valid,
  input  ROB_index_t                       save_ROB_index,
  output logic                             save_ready,
  output checkpoint_column_t               save_column,
  input  logic                             restore_valid,
  input  ROB_index_t                       restore_ROB_index,
  input  checkpoint_column_t               restore_column,
  output logic                             restore_success,
  input  logic                             release_valid,
  input  ROB_index_t                       release_ROB_index,
  input  checkpoint_column_t               release_column,
  output logic                             release_success,
  output checkpoint_column_t               checkpoint_count,
  output logic                             checkpoint_full
);

  map_column_t        columns_q [CHECKPOINT_COLUMNS];
  map_column_t        columns_d [CHECKPOINT_COLUMNS];
  checkpoint_column_t head_q, head_d;
  checkpoint_column_t working_q, working_d;

  phys_reg_tag_t [RENAME_WIDTH-1:0] src0_table_s, src1_table_s, old_table_s;
  logic          [RENAME_WIDTH-1:0] bypass_valid_s;
  logic               revert_any_s, restore_ok_s, release_ok_s, save_ok_s;
  checkpoint_column_t next_col_s, restore_span_s;

  // Table reads from the working column.
  always_comb begin
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      src0_table_s[k] = columns_q[working_q].map[src_arch_tag_0[k]];
      src1_table_s[k] = columns_q[working_q].map[src_arch_tag_1[k]];
      old_table_s[k]  = columns_q[working_q].map[rename_dest_arch_tag[k]];
    end
    bypass_valid_s = rename_valid & {RENAME_WIDTH{~RST}};
  end

  rename_bypass_network u_bypass (
    .src0_arch_i    (src_arch_tag_0),
    .src1_arch_i    (src_arch_tag_1),
    .dest_arch_i    (rename_dest_arch_tag),
    .rename_valid_i (bypass_valid_s),
    .dest_phys_i    (rename_dest_phys_tag),
    .src0_table_i   (src0_table_s),
    .src1_table_i   (src1_table_s),
    .old_table_i    (old_table_s),
    .src0_phys_o    (src_phys_tag_0),
    .src1_phys_o    (src_phys_tag_1),
    .old_phys_o     (old_dest_phys_tag)
  );

  // Occupancy flags and same-cycle success decisions.
  always_comb begin
    checkpoint_count = working_q - head_q;
    checkpoint_full  = (checkpoint_count == checkpoint_column_t'(CHECKPOINT_COLUMNS - 1));
    save_ready       = ~checkpoint_full;
    save_column      = working_q;
    revert_any_s     = |revert_valid;
    save_ok_s        = save_valid & save_ready;
    next_col_s       = working_q + checkpoint_column_t'(1);
    restore_span_s   = working_q - restore_column;
    restore_ok_s     = ~RST & restore_valid & ~revert_any_s
                     & columns_q[restore_column].valid
                     & (restore_column != working_q)
                     & (columns_q[restore_column].rob_index == restore_ROB_index);
    release_ok_s     = ~RST & release_valid
                     & columns_q[release_column].valid
                     & (release_column != working_q)
                     & (columns_q[release_column].rob_index == release_ROB_index)
                     & ~(restore_ok_s & (release_column == restore_column));
    restore_success  = restore_ok_s;
    release_success  = release_ok_s;
  end

  // Next-state: revert beats restore, which beats rename/save.
  always_comb begin
    columns_d = columns_q;
    working_d = working_q;
    if (head_q != working_q && !columns_q[head_q].valid) begin
      head_d = head_q + checkpoint_column_t'(1);
    end else begin
      head_d = head_q;
    end
    if (release_ok_s) begin
      columns_d[release_column].valid = 1'b0;
    end else begin
      columns_d[release_column].valid = columns_q[release_column].valid;
    end

    if (revert_any_s) begin
      for (int l = 0; l < RENAME_WIDTH; l++) begin
        if (revert_valid[l]) begin
          columns_d[working_q].map[revert_dest_arch_tag[l]] = revert_safe_phys_tag[l];
        end else begin
          columns_d[working_q].map = columns_d[working_q].map;
        end
      end
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        columns_d[c].valid = (checkpoint_column_t'(c) == working_q) ? columns_q[c].valid : 1'b0;
      end
      head_d = working_q;
    end else if (restore_ok_s) begin
      working_d = restore_column;
      for (int i = 1; i < CHECKPOINT_COLUMNS; i++) begin
        if (checkpoint_column_t'(i) <= restore_span_s) begin
          columns_d[restore_column + checkpoint_column_t'(i)].valid = 1'b0;
        end else begin
          columns_d[restore_column + checkpoint_column_t'(i)].valid =
            columns_d[restore_column + checkpoint_column_t'(i)].valid;
        end
      end
    end else begin
      for (int l = 0; l < RENAME_WIDTH; l++) begin
        if (rename_valid[l]) begin
          columns_d[working_q].map[rename_dest_arch_tag[l]] = rename_dest_phys_tag[l];
        end else begin
          columns_d[working_q].map = columns_d[working_q].map;
        end
      end
      // The new column inherits this cycle's renames.
      if (save_ok_s) begin
        columns_d[next_col_s].map       = columns_d[working_q].map;
        columns_d[next_col_s].valid     = 1'b1;
        columns_d[next_col_s].rob_index = save_ROB_index;
        columns_d[working_q].rob_index  = save_ROB_index;
        working_d                       = next_col_s;
      end else begin
        working_d = working_q;
      end
    end
  end

  // State registers; column 0 comes out of reset as the identity map.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        columns_q[c] <= (c == 0) ? identity_column() : map_column_t'('0);
      end
      head_q    <= '0;
      working_q <= '0;
    end else begin
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        columns_q[c] <= columns_d[c];
      end
      head_q    <= head_d;
      working_q <= working_d;
    end
  end

endmodule
